// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared state and owner encodings for the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    localparam logic OWN_DATA  = 1'b0;
    localparam logic OWN_INSTR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Data port, fetch port and RAM-side bundle of the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic [31:0] ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic [31:0] ram_data_out;

    logic        busy;

    // Arbiter side
    modport slave (
        input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, ram_data_out,
        output d_rdata, d_ack, i_rdata, i_ack,
               ram_address, ram_data_in, ram_write_enable, busy
    );

    // Requester / RAM side
    modport master (
        output d_req, d_we, d_addr, d_wdata, i_req, i_addr, ram_data_out,
        input  d_rdata, d_ack, i_rdata, i_ack,
               ram_address, ram_data_in, ram_write_enable, busy
    );

endinterface
`default_nettype wire

// File: rtl/ram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pick
// Description : Combinational winner select between data and fetch requests.
//               RAM_ARBITER_ROUND_ROBIN_EN selects alternating priority;
//               otherwise data wins unless fetch has waited MAX_WAIT grants.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_pick
    import ram_arb_pkg::*;
`ifndef RAM_ARBITER_ROUND_ROBIN_EN
#(
    parameter int MAX_WAIT = 2,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
)
`endif
(
    input  logic              d_req,
    input  logic              i_req,
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    input  logic              last_owner,
`else
    input  logic [WAIT_W-1:0] wait_cnt,
`endif
    output logic              grant,
    output logic              owner
);

    logic w_contend_owner;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    assign w_contend_owner = ~last_owner;
`else
    assign w_contend_owner = (wait_cnt == WAIT_W'(MAX_WAIT)) ? OWN_INSTR : OWN_DATA;
`endif

    always_comb begin
        grant = d_req | i_req;
        owner = OWN_DATA;
        if (d_req && i_req) begin
            owner = w_contend_owner;
        end else if (i_req) begin
            owner = OWN_INSTR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Non-pipelined req/ack arbiter sharing one RAM between the
//               data port and the fetch port. Define RAM_ARBITER_ROUND_ROBIN_EN
//               for alternating priority instead of the starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 2
)(
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    generate
        if (READ_LATENCY < 1 || MAX_WAIT < 1) begin : g_param_check
            $error("ram_arbiter: READ_LATENCY and MAX_WAIT must be >= 1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_we;
    logic             r_ram_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_d_rdata;
    logic [31:0]      r_i_rdata;

    logic             w_grant;
    logic             w_owner;
    logic             w_is_write;
    logic             w_take;

    assign w_take     = (r_state == IDLE) && w_grant;
    assign w_is_write = (w_owner == OWN_DATA) && bus.d_we;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic r_last_owner;

    ram_arb_pick u_pick (
        .d_req      (bus.d_req),
        .i_req      (bus.i_req),
        .last_owner (r_last_owner),
        .grant      (w_grant),
        .owner      (w_owner)
    );

    // Reset to fetch so that data takes the first contended grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_INSTR;
        end else if (w_take) begin
            r_last_owner <= w_owner;
        end
    end
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;

    ram_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_pick (
        .d_req    (bus.d_req),
        .i_req    (bus.i_req),
        .wait_cnt (r_wait_cnt),
        .grant    (w_grant),
        .owner    (w_owner)
    );

    // Counts data grants that made a pending fetch wait; any fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_take) begin
            if (w_owner == OWN_INSTR) begin
                r_wait_cnt <= '0;
            end else if (bus.i_req && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_owner   <= OWN_DATA;
            r_we      <= 1'b0;
            r_ram_we  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_d_rdata <= '0;
            r_i_rdata <= '0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_owner;
                        r_we     <= w_is_write;
                        r_ram_we <= w_is_write;
                        r_addr   <= (w_owner == OWN_INSTR) ? bus.i_addr : bus.d_addr;
                        if (w_owner == OWN_DATA) begin
                            r_wdata <= bus.d_wdata;
                        end
                        r_cnt   <= w_is_write ? CNT_W'(1) : CNT_W'(READ_LATENCY);
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt == CNT_W'(1)) begin
                        // Write completions leave d_rdata at its previous value.
                        if (r_owner == OWN_INSTR) begin
                            r_i_rdata <= bus.ram_data_out;
                        end else if (!r_we) begin
                            r_d_rdata <= bus.ram_data_out;
                        end
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_address      = r_addr;
    assign bus.ram_data_in      = r_wdata;
    assign bus.ram_write_enable = r_ram_we;
    assign bus.d_rdata          = r_d_rdata;
    assign bus.i_rdata          = r_i_rdata;
    assign bus.d_ack            = (r_state == ACK) && (r_owner == OWN_DATA);
    assign bus.i_ack            = (r_state == ACK) && (r_owner == OWN_INSTR);
    assign bus.busy             = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Scoreboard bench for ram_arbiter (READ_LATENCY 1 and 3 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ram_arbiter_if ifa ();
    ram_arbiter_if ifb ();

    ram_arbiter #(.READ_LATENCY(1), .MAX_WAIT(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    ram_arbiter #(.READ_LATENCY(3), .MAX_WAIT(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic        owner;     // 0 = data, 1 = fetch
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input int idx);
        return 32'hA5A5_0000 | 32'(idx);
    endfunction

    // RAM behind dut_a: combinational read, i.e. one cycle of read latency.
    logic [31:0] mem_a [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= (i == 4) ? 32'hDEAD_BEEF : mem_init(i);
        end else if (ifa.ram_write_enable) begin
            mem_a[ifa.ram_address[9:2]] <= ifa.ram_data_in;
        end
    end
    assign ifa.ram_data_out = mem_a[ifa.ram_address[9:2]];

    // RAM behind dut_b: two extra register stages give three cycles of latency.
    logic [31:0] mem_b [256];
    logic [31:0] b_s1, b_s2;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= (i == 16) ? 32'hC0FF_EE01 : mem_init(i);
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            if (ifb.ram_write_enable) mem_b[ifb.ram_address[9:2]] <= ifb.ram_data_in;
            b_s1 <= mem_b[ifb.ram_address[9:2]];
            b_s2 <= b_s1;
        end
    end
    assign ifb.ram_data_out = b_s2;

    // Monitors: pop the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        if (ifa.d_ack && ifa.i_ack) begin
            chk("a_dual_ack", 32'(ifa.d_ack & ifa.i_ack), 32'd0);
        end else if (ifa.d_ack || ifa.i_ack) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_ack", {30'b0, ifa.i_ack, ifa.d_ack}, 32'd0);
            end else begin
                ea = q_a.pop_front();
                chk("a_ack_owner", 32'(ifa.i_ack), 32'(ea.owner));
                if (ea.chk_data) chk("a_rdata", ea.owner ? ifa.i_rdata : ifa.d_rdata, ea.data);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.d_ack && ifb.i_ack) begin
            chk("b_dual_ack", 32'(ifb.d_ack & ifb.i_ack), 32'd0);
        end else if (ifb.d_ack || ifb.i_ack) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_ack", {30'b0, ifb.i_ack, ifb.d_ack}, 32'd0);
            end else begin
                eb = q_b.pop_front();
                chk("b_ack_owner", 32'(ifb.i_ack), 32'(eb.owner));
                if (eb.chk_data) chk("b_rdata", eb.owner ? ifb.i_rdata : ifb.d_rdata, eb.data);
            end
        end
    end

    // One transfer on dut_a; checks latency and the write-enable pulse.
    task automatic a_xfer(input logic instr, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data, input int exp_lat);
        exp_t e;
        int   n;
        int   we_cnt;
        logic [31:0] we_addr;
        logic got;
        e.owner = instr;
        e.chk_data = !we;
        e.data = exp_data;
        q_a.push_back(e);
        @(posedge clk); #1;
        if (instr) begin
            ifa.i_req = 1'b1; ifa.i_addr = addr;
        end else begin
            ifa.d_req = 1'b1; ifa.d_we = we; ifa.d_addr = addr; ifa.d_wdata = wdata;
        end
        n = 0; we_cnt = 0; we_addr = '0; got = 1'b0;
        while (!got && n <= 20) begin
            @(negedge clk);
            if (ifa.ram_write_enable) begin
                we_cnt++;
                we_addr = ifa.ram_address;
            end
            if (ifa.d_ack || ifa.i_ack) got = 1'b1;
            else n++;
        end
        chk("a_latency", n, exp_lat);
        if (we) begin
            chk("a_we_pulses", we_cnt, 1);
            chk("a_we_addr", we_addr, addr);
        end
        @(posedge clk); #1;
        ifa.d_req = 1'b0; ifa.i_req = 1'b0; ifa.d_we = 1'b0;
    endtask

    int          acks;
    int          cyc;
    int          nb;
    logic        got_b;
    logic [5:0]  order;
    exp_t        e_tmp;

    initial begin
        ifa.d_req = 1'b0; ifa.d_we = 1'b0; ifa.d_addr = '0; ifa.d_wdata = '0;
        ifa.i_req = 1'b0; ifa.i_addr = '0;
        ifb.d_req = 1'b0; ifb.d_we = 1'b0; ifb.d_addr = '0; ifb.d_wdata = '0;
        ifb.i_req = 1'b0; ifb.i_addr = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy",    32'(ifa.busy), 32'd0);
        chk("rst_d_ack",   32'(ifa.d_ack), 32'd0);
        chk("rst_i_ack",   32'(ifa.i_ack), 32'd0);
        chk("rst_we",      32'(ifa.ram_write_enable), 32'd0);
        chk("rst_addr",    ifa.ram_address, 32'd0);
        chk("rst_wdata",   ifa.ram_data_in, 32'd0);
        chk("rst_d_rdata", ifa.d_rdata, 32'd0);
        chk("rst_i_rdata", ifa.i_rdata, 32'd0);
        chk("rst_b_busy",  32'(ifb.busy), 32'd0);

        // Fetch alone with READ_LATENCY=3: ack at t+4, busy t+1..t+4.
        e_tmp.owner = 1'b1; e_tmp.chk_data = 1'b1; e_tmp.data = 32'hC0FF_EE01;
        q_b.push_back(e_tmp);
        @(posedge clk); #1;
        ifb.i_req = 1'b1; ifb.i_addr = 32'h40;
        nb = 0; got_b = 1'b0;
        while (!got_b && nb <= 20) begin
            @(negedge clk);
            chk("b_busy", 32'(ifb.busy), 32'(nb >= 1));
            if (ifb.i_ack) got_b = 1'b1;
            else nb++;
        end
        chk("b_fetch_latency", nb, 4);
        @(posedge clk); #1 ifb.i_req = 1'b0;
        @(negedge clk);
        chk("b_busy_after", 32'(ifb.busy), 32'd0);

        // Single-requester transfers on dut_a (READ_LATENCY=1).
        a_xfer(1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 2);
        a_xfer(1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'h0,         2);
        a_xfer(1'b0, 1'b0, 32'h20, 32'h0,         32'h1234_5678, 2);
        a_xfer(1'b1, 1'b0, 32'h44, 32'h0,         mem_init(17),  2);
        @(negedge clk);
        chk("a_d_rdata_hold", ifa.d_rdata, 32'h1234_5678);
        chk("a_busy_idle", 32'(ifa.busy), 32'd0);

        // Contention: both requests held continuously from a fresh reset.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        order = 6'b101010;  // D,I,D,I,D,I (bit i = grant i)
`else
        order = 6'b100100;  // D,D,I,D,D,I
`endif
        for (int i = 0; i < 6; i++) begin
            e_tmp.owner = order[i];
            e_tmp.chk_data = 1'b1;
            e_tmp.data = order[i] ? mem_init(9) : 32'hDEAD_BEEF;
            q_a.push_back(e_tmp);
        end
        ifa.d_req = 1'b1; ifa.d_we = 1'b0; ifa.d_addr = 32'h10;
        ifa.i_req = 1'b1; ifa.i_addr = 32'h24;
        acks = 0; cyc = 0;
        while (acks < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ifa.d_ack || ifa.i_ack) acks++;
        end
        chk("a_contention_acks", acks, 6);
        @(posedge clk); #1;
        ifa.d_req = 1'b0; ifa.i_req = 1'b0;

        // Reset during the first ACCESS cycle of a write.
        repeat (2) @(posedge clk);
        #1;
        ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 32'h30; ifa.d_wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        chk("a_mid_we_first", 32'(ifa.ram_write_enable), 32'd1);
        chk("a_mid_busy", 32'(ifa.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ifa.d_req = 1'b0; ifa.d_we = 1'b0;
        @(negedge clk);
        chk("a_abort_busy",    32'(ifa.busy), 32'd0);
        chk("a_abort_we",      32'(ifa.ram_write_enable), 32'd0);
        chk("a_abort_d_ack",   32'(ifa.d_ack), 32'd0);
        chk("a_abort_addr",    ifa.ram_address, 32'd0);
        chk("a_abort_wdata",   ifa.ram_data_in, 32'd0);
        chk("a_abort_d_rdata", ifa.d_rdata, 32'd0);
        chk("a_abort_i_rdata", ifa.i_rdata, 32'd0);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters: the memory stage (data port, read/write) and an instruction-fetch port (read-only), for unified instruction/data memory builds.
- Sits between the memory/fetch stages and the RAM instance, and owns the RAM address, write-data and write-enable signals.
- Non-pipelined: one access in flight at a time.
- Uses a req/ack handshake and fixed data priority, with a starvation guard for fetch.

Parameters:
- READ_LATENCY, 1, cycles from RAM address presented to ram_data_out valid (>=1).
- MAX_WAIT, 2, consecutive contended data grants before fetch is forced to win (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address, passed unchanged
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- i_req  in  1  fetch read request; held with i_addr until i_ack
- i_addr  in  32  fetch address
- i_rdata  out  32  fetched word, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse
- ram_address  out  32  to RAM
- ram_data_in  out  32  to RAM
- ram_write_enable  out  1  to RAM
- ram_data_out  in  32  from RAM
- busy  out  1  1 when state is not IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset values: state=IDLE; all outputs 0; wait_cnt=0; latched owner/we/addr/wdata=0.
- States: IDLE, ACCESS, ACK.
- IDLE, no request: stays in IDLE.
- IDLE, any request present:
  - Pick a winner.
  - Register ram_address, ram_data_in and owner.
  - Set ram_write_enable=1 if the winner is a data write.
  - Load cnt = (write ? 1 : READ_LATENCY).
  - Go to ACCESS.
- ACCESS:
  - ram_write_enable is high only in the first ACCESS cycle (exactly one cycle per write).
  - cnt decrements each cycle.
  - When cnt reaches 1: capture ram_data_out into the owner's rdata and go to ACK.
- ACK:
  - Owner's ack=1 for exactly one cycle; requests are ignored in this cycle.
  - Next state is IDLE.
  - The requester must drop req, or present a new request, by the next cycle.
- Latency: request sampled in IDLE at cycle t gives ack at t+1+READ_LATENCY for a read, t+2 for a write.
- Throughput: at most one access per (latency+2) cycles.
- d_rdata for writes: undefined but held stable.
- i_rdata/d_rdata: hold their last value between acks.
- Winner selection:
  - Only one requester present: it wins.
  - Both present and wait_cnt<MAX_WAIT: data wins, and wait_cnt increments.
  - Both present and wait_cnt==MAX_WAIT: fetch wins.
  - Any fetch grant clears wait_cnt.
  - A data grant without i_req pending leaves wait_cnt unchanged.
- wait_cnt width is $clog2(MAX_WAIT+1) and saturates at MAX_WAIT.
- Requests arriving in ACCESS/ACK: wait; they are not queued beyond the level-held req.
- Reset mid-access: abandons the transfer; no ack is issued, and ram_write_enable drops on the next edge.
- Address alignment is not checked; misaligned addresses pass through unchanged.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined: on contention, the port not granted last wins (last_owner register, reset to fetch so data wins the first contention); wait_cnt and MAX_WAIT are unused.
- Undefined: fixed data priority with the MAX_WAIT starvation guard, as described above.

Decomposition:
- Package ram_arb_pkg holds:
  - state localparams: IDLE=2'd0, ACCESS=2'd1, ACK=2'd2.
  - owner encoding: OWN_DATA=1'b0, OWN_INSTR=1'b1.
- Sub-module ram_arb_pick: combinational winner select (inputs d_req, i_req, wait_cnt/last_owner; outputs grant and owner). It isolates the macro-dependent policy.

Test Plan:
- d_req read addr 0x10 with RAM[0x10]=0xDEADBEEF, READ_LATENCY=1, sampled at cycle t -> d_ack=1 at t+2, d_rdata=0xDEADBEEF, i_ack stays 0.
- d_req write addr 0x20, wdata 0x12345678 -> ram_write_enable high for exactly one cycle with ram_address=0x20; d_ack at t+2; a following read of 0x20 returns 0x12345678.
- i_req alone, i_addr 0x40, READ_LATENCY=3 -> i_ack at t+4; i_rdata=RAM[0x40]; busy=1 from t+1 to t+4.
- d_req and i_req held continuously, MAX_WAIT=2, macro undefined -> grant order D,D,I,D,D,I.
- Same stimulus with RAM_ARBITER_ROUND_ROBIN_EN defined -> grant order D,I,D,I.
- rst asserted during the first ACCESS cycle of a write -> next cycle busy=0, no ack, ram_write_enable=0, outputs at their reset values.
